// File: rtl/mux16_pkg.sv
// ============================================================================
// Module      : mux16_pkg
// Description : Shared constants and the select-code type for the mux16 demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux16_pkg;

    localparam int NUM_OUT = 16;
    localparam int SEL_W   = 4;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

`default_nettype wire

// File: rtl/mux16_dec4to16.sv
// ============================================================================
// Module      : dec4to16
// Description : Plain 4-to-16 one-hot decoder; every select code is legal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec4to16
    import mux16_pkg::*;
(
    input  sel_t               i_sel,
    output logic [NUM_OUT-1:0] o_onehot
);

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_dec
        assign o_onehot[k] = (i_sel == sel_t'(k));
    end

endmodule

`default_nettype wire

// File: rtl/mux16.sv
// ============================================================================
// Module      : mux16
// Description : 1-to-16 demultiplexer routing ip to s[{a3,a2,a1,a0}], with
//               unselected outputs at IDLE_VAL. Outputs are registered unless
//               MUX16_BYPASS_EN is defined, which makes them combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux16
    import mux16_pkg::*;
#(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ip,
    input  logic a3,
    input  logic a2,
    input  logic a1,
    input  logic a0,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5,
    output logic s6,
    output logic s7,
    output logic s8,
    output logic s9,
    output logic s10,
    output logic s11,
    output logic s12,
    output logic s13,
    output logic s14,
    output logic s15
);

    sel_t               w_sel;
    logic [NUM_OUT-1:0] w_onehot;
    logic [NUM_OUT-1:0] w_next;
    logic [NUM_OUT-1:0] w_out;

    assign w_sel = {a3, a2, a1, a0};

    dec4to16 u_dec (
        .i_sel    (w_sel),
        .o_onehot (w_onehot)
    );

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_gate
        assign w_next[k] = w_onehot[k] ? ip : IDLE_VAL;
    end

`ifdef MUX16_BYPASS_EN
    assign w_out = w_next;
`else
    logic [NUM_OUT-1:0] r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= {NUM_OUT{IDLE_VAL}};
        end else begin
            r_out <= w_next;
        end
    end

    assign w_out = r_out;
`endif

    assign s0  = w_out[0];
    assign s1  = w_out[1];
    assign s2  = w_out[2];
    assign s3  = w_out[3];
    assign s4  = w_out[4];
    assign s5  = w_out[5];
    assign s6  = w_out[6];
    assign s7  = w_out[7];
    assign s8  = w_out[8];
    assign s9  = w_out[9];
    assign s10 = w_out[10];
    assign s11 = w_out[11];
    assign s12 = w_out[12];
    assign s13 = w_out[13];
    assign s14 = w_out[14];
    assign s15 = w_out[15];

`ifndef SYNTHESIS
    // An unknown select would silently pick an arbitrary output downstream.
    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(w_sel))
        else $error("mux16: select bits are X/Z");
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux16.sv
// ============================================================================
// Module      : tb_mux16
// Description : Directed self-checking bench for mux16 (registered build by
//               default, combinational checks when MUX16_BYPASS_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux16;

    logic       clk;
    logic       rst_n;
    logic       ip;
    logic [3:0] sel;
    logic       s0, s1, s2, s3, s4, s5, s6, s7;
    logic       s8, s9, s10, s11, s12, s13, s14, s15;
    logic [15:0] w_s;

    int tests_run;
    int tests_failed;

    assign w_s = {s15, s14, s13, s12, s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1, s0};

    mux16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ip    (ip),
        .a3    (sel[3]),
        .a2    (sel[2]),
        .a1    (sel[1]),
        .a0    (sel[0]),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3),
        .s4    (s4),
        .s5    (s5),
        .s6    (s6),
        .s7    (s7),
        .s8    (s8),
        .s9    (s9),
        .s10   (s10),
        .s11   (s11),
        .s12   (s12),
        .s13   (s13),
        .s14   (s14),
        .s15   (s15)
    );

    initial clk = 1'b0;
`ifndef MUX16_BYPASS_EN
    always #5 clk = ~clk;
`endif

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

`ifndef MUX16_BYPASS_EN
    task automatic test_reset;
        rst_n = 1'b1;
        ip    = 1'b1;
        sel   = 4'd5;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_immediate got=%h exp=%h", w_s, 16'h0000);
        end
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_hold got=%h exp=%h", w_s, 16'h0000);
        end
        #3;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_release_pre_edge got=%h exp=%h", w_s, 16'h0000);
        end
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h0020) begin
            tests_failed++;
            $display("FAIL reset_first_load got=%h exp=%h", w_s, 16'h0020);
        end
    endtask

    task automatic test_sweep;
        logic [15:0] exp;
        ip = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            @(posedge clk); #1;
            exp = 16'h0001 << i;
            tests_run++;
            if (w_s !== exp) begin
                tests_failed++;
                $display("FAIL sweep sel=%0d got=%h exp=%h", i, w_s, exp);
            end
        end
    endtask

    task automatic test_gating;
        ip  = 1'b0;
        sel = 4'd9;
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL gating_ip0 got=%h exp=%h", w_s, 16'h0000);
        end
        ip = 1'b1;
        #2;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL gating_hold_pre_edge got=%h exp=%h", w_s, 16'h0000);
        end
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h0200) begin
            tests_failed++;
            $display("FAIL gating_ip1 got=%h exp=%h", w_s, 16'h0200);
        end
    endtask

    task automatic test_latency;
        ip  = 1'b1;
        sel = 4'd3;
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h0008) begin
            tests_failed++;
            $display("FAIL latency_s3 got=%h exp=%h", w_s, 16'h0008);
        end
        #3;
        sel = 4'd12;
        #2;
        tests_run++;
        if (w_s !== 16'h0008) begin
            tests_failed++;
            $display("FAIL latency_hold got=%h exp=%h", w_s, 16'h0008);
        end
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h1000) begin
            tests_failed++;
            $display("FAIL latency_s12 got=%h exp=%h", w_s, 16'h1000);
        end
    endtask

    task automatic test_async_reset;
        ip  = 1'b1;
        sel = 4'd15;
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h8000) begin
            tests_failed++;
            $display("FAIL async_pre got=%h exp=%h", w_s, 16'h8000);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_clear got=%h exp=%h", w_s, 16'h0000);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (w_s !== 16'h8000) begin
            tests_failed++;
            $display("FAIL async_recover got=%h exp=%h", w_s, 16'h8000);
        end
    endtask
`else
    task automatic test_bypass;
        logic [15:0] exp;
        rst_n = 1'b0;
        ip    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            #1;
            exp = 16'h0001 << i;
            tests_run++;
            if (w_s !== exp) begin
                tests_failed++;
                $display("FAIL bypass sel=%0d got=%h exp=%h", i, w_s, exp);
            end
            #4;
        end
        ip = 1'b0;
        #1;
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL bypass_ip0 got=%h exp=%h", w_s, 16'h0000);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        ip           = 1'b0;
        sel          = 4'd0;
        #2;
`ifndef MUX16_BYPASS_EN
        tests_run++;
        if (w_s !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_state got=%h exp=%h", w_s, 16'h0000);
        end
        test_reset();
        test_sweep();
        test_gating();
        test_latency();
        test_async_reset();
`else
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux16.md
MUX16 -- requirements
Module: mux16

Interface
REQ-001 Parameter IDLE_VAL, default 1'b0, the level driven on every unselected output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ip  input  1  data bit to be routed.
REQ-005 a3  input  1  select bit 3 (MSB).
REQ-006 a2  input  1  select bit 2.
REQ-007 a1  input  1  select bit 1.
REQ-008 a0  input  1  select bit 0 (LSB).
REQ-009 s0 .. s15  output  1 each  demultiplexed outputs, one port per index k = 0..15.
REQ-010 Port order SHALL be clk, rst_n, ip, a3, a2, a1, a0, s0 .. s15.

Function
REQ-011 Select index sel SHALL be {a3,a2,a1,a0}, unsigned, range 0..15.
REQ-012 Output s[sel] SHALL be driven with ip; every other output SHALL be driven with IDLE_VAL.
REQ-013 With ip = 0 and IDLE_VAL = 0, all sixteen outputs SHALL be 0.
REQ-014 Default build: outputs SHALL be registered; a change on ip or select captured at rising edge N SHALL appear on the outputs immediately after edge N (one-cycle latency).
REQ-015 Between edges, outputs SHALL hold their registered value, regardless of input activity.
REQ-016 At most one output SHALL differ from IDLE_VAL in any cycle.
REQ-017 Select wrap-around is not applicable: all 16 codes are legal and decode to distinct outputs; no code is reserved.
REQ-018 X or Z on any select bit SHALL NOT be required to produce defined outputs.
REQ-019 Simulation assertions SHALL flag X or Z on any select bit while rst_n = 1.

Reset
REQ-020 rst_n = 0 SHALL immediately force all registered outputs to IDLE_VAL, independent of clk.
REQ-021 While rst_n = 0, outputs SHALL remain at IDLE_VAL.
REQ-022 After rst_n deasserts, the first rising edge SHALL load the decoded value.
REQ-023 Reset asserted mid-operation SHALL discard the current selection with no residual output.

Configuration
REQ-024 Macro MUX16_BYPASS_EN, when defined, SHALL make all outputs purely combinational from ip and a3..a0, with zero latency.
REQ-025 With MUX16_BYPASS_EN defined, clk and rst_n SHALL remain ports but have no effect.
REQ-026 With MUX16_BYPASS_EN undefined, the registered behaviour of REQ-014 and the reset behaviour of REQ-020..023 SHALL apply.

Structure
REQ-027 A shared package mux16_pkg SHALL hold the constants NUM_OUT = 16 and SEL_W = 4 and the select typedef sel_t (SEL_W bits).
REQ-028 The 4-to-16 one-hot decode SHALL be a sub-module dec4to16 (input sel_t, output 16-bit one-hot).
REQ-029 The top level SHALL gate the one-hot vector with ip, apply IDLE_VAL, register the result (or bypass it), and fan it out to s0..s15.

Verification
REQ-030 Reset: rst_n = 0 with ip = 1, sel = 5 -> all outputs 0 immediately; after release, s5 = 1 following the next rising edge.
REQ-031 Sweep: ip = 1, sel = 0..15 stepped once per cycle -> one cycle later exactly s[sel] = 1, all others 0.
REQ-032 Data gating: ip = 0, sel = 9 -> all outputs 0; ip then toggled to 1 -> s9 = 1 after the next edge.
REQ-033 Latency: sel changed 3 -> 12 mid-cycle -> s3 stays 1 until the edge, then s12 = 1 and s3 = 0.
REQ-034 Async reset mid-run: rst_n pulsed low between edges while s15 = 1 -> s15 = 0 immediately, before any edge.
REQ-035 Bypass build (MUX16_BYPASS_EN defined), no clock toggling: sel = 0..15 stepped every 5 time units with ip = 1 -> s[sel] = 1 within the same time step.
